// File: rtl/pe_link_fifo.sv
// pe_link_fifo: elastic word buffer between a producer PE's onfifo/opfifo
// and the next PE's infifo; registered read port, sticky error flags.
module pe_link_fifo #(
  parameter int DW       = 16,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [DW-1:0]            wr_data,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     rd_en,
  output logic [DW-1:0]            rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic                     udf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_acc;
  logic          rd_acc;

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= CW'(AF_LEVEL));

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  // Storage: not reset; a flush only moves the pointers.
  always_ff @(posedge clk) begin
    if (wr_acc && !clr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy, read port and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + AW'(1);
      end
      rd_valid <= rd_acc;
      count    <= count + CW'(wr_acc) - CW'(rd_acc);
      ovf      <= ovf | (wr_en & full);
      udf      <= udf | (rd_en & empty);
    end
  end

endmodule

// File: tb/tb_pe_link_fifo.sv
// tb_pe_link_fifo: vector table, directed corner sequences and random
// traffic checked against a queue-based model of the link buffer.
module tb_pe_link_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        full;
  logic        almost_full;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        empty;
  logic [4:0]  count;
  logic        ovf;
  logic        udf;

  int total = 0;
  int bad   = 0;

  logic [15:0] q[$];
  logic [15:0] m_rd;
  logic        m_rv;
  logic        m_ovf;
  logic        m_udf;

  typedef struct {
    logic        w;
    logic        r;
    logic [15:0] d;
    int          cnt;
    logic        rv;
    logic [15:0] rd;
    logic        ov;
    logic        ud;
    logic        em;
  } vec_t;

  vec_t tbl[9];

  pe_link_fifo #(
    .DW(16),
    .DEPTH(16),
    .AF_LEVEL(12)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .full(full),
    .almost_full(almost_full),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .empty(empty),
    .count(count),
    .ovf(ovf),
    .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rd  = '0;
    m_rv  = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic model_step(input logic c, input logic w,
                            input logic r, input logic [15:0] d);
    bit f;
    bit e;
    if (c) begin
      q.delete();
      m_rv  = 1'b0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      f = (q.size() == 16);
      e = (q.size() == 0);
      m_ovf = m_ovf | (w & f);
      m_udf = m_udf | (r & e);
      m_rv  = r && !e;
      if (m_rv) m_rd = q.pop_front();
      if (w && !f) q.push_back(d);
    end
  endtask

  task automatic cyc(input logic c, input logic w,
                     input logic r, input logic [15:0] d);
    @(negedge clk);
    clr     = c;
    wr_en   = w;
    rd_en   = r;
    wr_data = d;
    @(posedge clk);
    model_step(c, w, r, d);
    #1;
  endtask

  task automatic check_model(input string nm);
    chk({nm, ".count"}, 32'(count), 32'(q.size()));
    chk({nm, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({nm, ".full"}, 32'(full), 32'(q.size() == 16));
    chk({nm, ".af"}, 32'(almost_full), 32'(q.size() >= 12));
    chk({nm, ".rv"}, 32'(rd_valid), 32'(m_rv));
    chk({nm, ".rd"}, 32'(rd_data), 32'(m_rd));
    chk({nm, ".ovf"}, 32'(ovf), 32'(m_ovf));
    chk({nm, ".udf"}, 32'(udf), 32'(m_udf));
  endtask

  initial begin
    tbl[0] = '{1, 0, 16'h3C00, 1, 0, 16'h0000, 0, 0, 0};
    tbl[1] = '{1, 0, 16'h4000, 2, 0, 16'h0000, 0, 0, 0};
    tbl[2] = '{1, 0, 16'h4200, 3, 0, 16'h0000, 0, 0, 0};
    tbl[3] = '{0, 1, 16'h0000, 2, 1, 16'h3C00, 0, 0, 0};
    tbl[4] = '{0, 1, 16'h0000, 1, 1, 16'h4000, 0, 0, 0};
    tbl[5] = '{0, 1, 16'h0000, 0, 1, 16'h4200, 0, 0, 1};
    tbl[6] = '{1, 1, 16'h1234, 1, 0, 16'h4200, 0, 1, 0};
    tbl[7] = '{0, 1, 16'h0000, 0, 1, 16'h1234, 0, 1, 1};
    tbl[8] = '{0, 0, 16'h0000, 0, 0, 16'h1234, 0, 1, 1};

    rst_n   = 1'b0;
    clr     = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    model_reset();
    #1;
    chk("rst.count", 32'(count), 0);
    chk("rst.empty", 32'(empty), 1);
    chk("rst.full", 32'(full), 0);
    chk("rst.af", 32'(almost_full), 0);
    chk("rst.rv", 32'(rd_valid), 0);
    chk("rst.rd", 32'(rd_data), 0);
    chk("rst.ovf", 32'(ovf), 0);
    chk("rst.udf", 32'(udf), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic ordering, empty read with same-cycle write
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, tbl[i].w, tbl[i].r, tbl[i].d);
      chk($sformatf("vec%0d.count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d.rv", i), 32'(rd_valid), 32'(tbl[i].rv));
      chk($sformatf("vec%0d.rd", i), 32'(rd_data), 32'(tbl[i].rd));
      chk($sformatf("vec%0d.ovf", i), 32'(ovf), 32'(tbl[i].ov));
      chk($sformatf("vec%0d.udf", i), 32'(udf), 32'(tbl[i].ud));
      chk($sformatf("vec%0d.empty", i), 32'(empty), 32'(tbl[i].em));
    end

    // fill to full, overflow, drain
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    chk("clr.udf", 32'(udf), 0);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 16'(i));
      chk($sformatf("fill%0d.af", i), 32'(almost_full), 32'(i >= 11));
      chk($sformatf("fill%0d.full", i), 32'(full), 32'(i == 15));
      check_model($sformatf("fill%0d", i));
    end
    cyc(1'b0, 1'b1, 1'b0, 16'hFFFF);
    chk("ovf.flag", 32'(ovf), 1);
    chk("ovf.count", 32'(count), 16);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 16'h0);
      chk($sformatf("drain%0d.rd", i), 32'(rd_data), 32'(i));
      chk($sformatf("drain%0d.rv", i), 32'(rd_valid), 1);
    end
    chk("drain.empty", 32'(empty), 1);
    chk("drain.ovf", 32'(ovf), 1);

    // full with simultaneous read and write
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 1'b0, 16'hA000 + 16'(i));
    cyc(1'b0, 1'b1, 1'b1, 16'hBEEF);
    chk("fullrw.count", 32'(count), 15);
    chk("fullrw.ovf", 32'(ovf), 1);
    chk("fullrw.rd", 32'(rd_data), 32'h0000A000);
    chk("fullrw.rv", 32'(rd_valid), 1);
    check_model("fullrw");

    // pointer wrap with steady occupancy
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 16'h0100 + 16'(i));
    for (int k = 0; k < 40; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 16'h0105 + 16'(k));
      chk($sformatf("wrap%0d.rd", k), 32'(rd_data), 32'(16'h0100 + 16'(k)));
      chk($sformatf("wrap%0d.count", k), 32'(count), 5);
      check_model($sformatf("wrap%0d", k));
    end

    // async reset pulse mid-stream
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b1, 16'h0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 16'h7000 + 16'(i));
    cyc(1'b0, 1'b0, 1'b1, 16'h0);
    chk("pre.count", 32'(count), 7);
    chk("pre.udf", 32'(udf), 1);
    @(negedge clk);
    clr   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst.count", 32'(count), 0);
    chk("arst.empty", 32'(empty), 1);
    chk("arst.rv", 32'(rd_valid), 0);
    chk("arst.rd", 32'(rd_data), 0);
    chk("arst.udf", 32'(udf), 0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 16'h2468);
    cyc(1'b0, 1'b0, 1'b1, 16'h0);
    chk("arst.first", 32'(rd_data), 32'h00002468);
    check_model("arst");

    // synchronous clear beats same-cycle read/write
    cyc(1'b0, 1'b0, 1'b1, 16'h0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 16'h6000 + 16'(i));
    cyc(1'b0, 1'b0, 1'b1, 16'h0);
    chk("preclr.udf", 32'(udf), 1);
    cyc(1'b1, 1'b1, 1'b1, 16'h5555);
    chk("clr.count", 32'(count), 0);
    chk("clr.ovf", 32'(ovf), 0);
    chk("clr.udf2", 32'(udf), 0);
    chk("clr.rv", 32'(rd_valid), 0);
    chk("clr.rd", 32'(rd_data), 32'h00006000);
    check_model("clr");

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic c;
      logic w;
      logic r;
      c = ($urandom_range(0, 99) == 0);
      w = ($urandom_range(0, 99) < ((n / 500) % 2 ? 70 : 40));
      r = ($urandom_range(0, 99) < ((n / 500) % 2 ? 40 : 70));
      cyc(c, w, r, 16'($urandom));
      check_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
